// File: rtl/capture_controller.sv
// Capture sequencer: registers samples into a current/previous pair, drives ring buffer writes, and runs arm/pre/wait/post.
// One-cycle strobe-to-write latency and two cycles from strobe to trigger accept; no backpressure, one sample per clock.
module capture_controller #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 10
) (
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic              in_arm,
   input  logic              in_abort,
   input  logic              in_sample_en,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_pre_len,
   input  logic [ADDR_W-1:0] in_post_len,
   input  logic              in_trig,
   output logic [DATA_W-1:0] out_prev,
   output logic [DATA_W-1:0] out_data,
   output logic              out_wr_en,
   output logic [ADDR_W-1:0] out_wr_addr,
   output logic [DATA_W-1:0] out_wr_data,
   output logic [ADDR_W-1:0] out_trig_addr,
   output logic [1:0]        out_state,
   output logic              out_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_WAIT = 2'd2,
      ST_POST = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   ONE_X = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   prev_q, prev_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
   logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
   logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
   logic [1:0]          smp_cnt_q, smp_cnt_d;
   logic                fresh_q, fresh_d;
   logic                done_q, done_d;

   logic                active;
   logic                accept;
   logic                capture;
   logic [ADDR_W:0]     pre_nxt;
   logic [ADDR_W:0]     post_base;
   logic [ADDR_W:0]     post_nxt;

   assign active  = (state_q != ST_IDLE);
   // A trigger only counts against a genuine prev/current pair taken on the previous edge.
   assign accept  = (state_q == ST_WAIT) && in_trig && fresh_q && (smp_cnt_q == 2'd2);
   // With a zero post length the capture ends on the accept edge, so that edge writes nothing.
   assign capture = active && in_sample_en && !in_abort && !(accept && (in_post_len == '0));

   assign pre_nxt   = {1'b0, pre_cnt_q} + ONE_X;
   assign post_base = accept ? '0 : {1'b0, post_cnt_q};
   assign post_nxt  = post_base + {{ADDR_W{1'b0}}, capture};

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      data_d      = data_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      ptr_d       = ptr_q;
      trig_addr_d = trig_addr_q;
      pre_cnt_d   = pre_cnt_q;
      post_cnt_d  = post_cnt_q;
      smp_cnt_d   = smp_cnt_q;
      fresh_d     = capture;
      done_d      = done_q;

      if (capture) begin
         prev_d    = data_q;
         data_d    = in_data;
         wr_en_d   = 1'b1;
         wr_addr_d = ptr_q;
         ptr_d     = ptr_q + ONE_A;
         if (smp_cnt_q != 2'd2) begin
            smp_cnt_d = smp_cnt_q + 2'd1;
         end
      end

      if (in_abort) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
      end else if (!active) begin
         if (in_arm) begin
            done_d     = 1'b0;
            ptr_d      = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            smp_cnt_d  = 2'd0;
            fresh_d    = 1'b0;
            state_d    = (in_pre_len == '0) ? ST_WAIT : ST_PRE;
         end
      end else begin
         case (state_q)
            ST_PRE: begin
               if (capture) begin
                  pre_cnt_d = pre_nxt[ADDR_W-1:0];
                  if (pre_nxt == {1'b0, in_pre_len}) begin
                     state_d = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (accept) begin
                  trig_addr_d = wr_addr_q;
                  post_cnt_d  = post_nxt[ADDR_W-1:0];
                  state_d     = ST_POST;
                  if (post_nxt == {1'b0, in_post_len}) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_POST: begin
               if (capture) begin
                  post_cnt_d = post_nxt[ADDR_W-1:0];
                  if (post_nxt == {1'b0, in_post_len}) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q     <= ST_IDLE;
         prev_q      <= '0;
         data_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         ptr_q       <= '0;
         trig_addr_q <= '0;
         pre_cnt_q   <= '0;
         post_cnt_q  <= '0;
         smp_cnt_q   <= 2'd0;
         fresh_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         data_q      <= data_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         ptr_q       <= ptr_d;
         trig_addr_q <= trig_addr_d;
         pre_cnt_q   <= pre_cnt_d;
         post_cnt_q  <= post_cnt_d;
         smp_cnt_q   <= smp_cnt_d;
         fresh_q     <= fresh_d;
         done_q      <= done_d;
      end
   end

   assign out_prev      = prev_q;
   assign out_data      = data_q;
   assign out_wr_en     = wr_en_q;
   assign out_wr_addr   = wr_addr_q;
   assign out_wr_data   = data_q;
   assign out_trig_addr = trig_addr_q;
   assign out_state     = state_q;
   assign out_done      = done_q;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller: a default-width instance plus a 4-bit-address instance for wrap.
module tb_capture_controller;
   localparam int DW  = 64;
   localparam int AW  = 10;
   localparam int AWS = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          sen = 1'b0;
   logic [DW-1:0] din = '0;
   logic [AW-1:0] pre_len = '0;
   logic [AW-1:0] post_len = '0;
   logic          trig_en = 1'b0;
   logic          trig_hold = 1'b0;
   logic [DW-1:0] trig_val = '0;
   logic          trig_m, trig_s;

   logic [DW-1:0]  m_prev, m_data, m_wr_data;
   logic           m_wr_en, m_done;
   logic [AW-1:0]  m_wr_addr, m_trig_addr;
   logic [1:0]     m_state;
   logic [DW-1:0]  s_prev, s_data, s_wr_data;
   logic           s_wr_en, s_done;
   logic [AWS-1:0] s_wr_addr, s_trig_addr;
   logic [1:0]     s_state;

   int            checks = 0;
   int            failures = 0;
   int            wr_cnt = 0;
   int            s_wr_cnt = 0;
   logic [AW-1:0] last_addr = '0;
   logic [AWS-1:0] s_last = '0;
   logic [1:0]    seq[$];

   assign trig_m = trig_hold | (trig_en && (m_data == trig_val));
   assign trig_s = trig_hold | (trig_en && (s_data == trig_val));

   always #5 clk = ~clk;

   capture_controller #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .in_clk(clk), .in_rst_n(rst_n), .in_arm(arm), .in_abort(abort),
      .in_sample_en(sen), .in_data(din), .in_pre_len(pre_len), .in_post_len(post_len),
      .in_trig(trig_m), .out_prev(m_prev), .out_data(m_data), .out_wr_en(m_wr_en),
      .out_wr_addr(m_wr_addr), .out_wr_data(m_wr_data), .out_trig_addr(m_trig_addr),
      .out_state(m_state), .out_done(m_done)
   );

   capture_controller #(.DATA_W(DW), .ADDR_W(AWS)) dut_s (
      .in_clk(clk), .in_rst_n(rst_n), .in_arm(arm), .in_abort(abort),
      .in_sample_en(sen), .in_data(din), .in_pre_len(pre_len[AWS-1:0]),
      .in_post_len(post_len[AWS-1:0]), .in_trig(trig_s), .out_prev(s_prev),
      .out_data(s_data), .out_wr_en(s_wr_en), .out_wr_addr(s_wr_addr),
      .out_wr_data(s_wr_data), .out_trig_addr(s_trig_addr), .out_state(s_state),
      .out_done(s_done)
   );

   // Advance one clock; inputs change and outputs are observed 1 time unit after the edge.
   task automatic step();
      logic en;
      en = sen;
      @(posedge clk);
      #1;
      arm = 1'b0;
      abort = 1'b0;
      if (en) din = din + 64'd1;
      if (m_wr_en) begin wr_cnt++; last_addr = m_wr_addr; end
      if (s_wr_en) begin s_wr_cnt++; s_last = s_wr_addr; end
      if (seq.size() > 0 && seq[seq.size()-1] != m_state) seq.push_back(m_state);
   endtask

   task automatic start(input logic [AW-1:0] pre, input logic [AW-1:0] post);
      pre_len = pre;
      post_len = post;
      sen = 1'b0;
      trig_en = 1'b0;
      trig_hold = 1'b0;
      arm = 1'b1;
      step();
      din = '0;
      wr_cnt = 0;
      s_wr_cnt = 0;
      last_addr = '0;
      s_last = '0;
      seq.delete();
      seq.push_back(m_state);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({m_prev, m_data, m_wr_en, m_wr_addr, m_wr_data, m_trig_addr, m_state, m_done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: prev=%0h data=%0h wr_en=%0b addr=%0d trig_addr=%0d state=%0d done=%0b, required all 0",
                  m_prev, m_data, m_wr_en, m_wr_addr, m_trig_addr, m_state, m_done);
      end
      checks++;
      if ({s_prev, s_data, s_wr_en, s_wr_addr, s_wr_data, s_trig_addr, s_state, s_done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs_small: some output nonzero (state=%0d addr=%0d), required all 0", s_state, s_wr_addr);
      end
      #10 rst_n = 1'b1;
      sen = 1'b1;
      step(); step(); step();
      checks++;
      if (wr_cnt !== 0 || m_state !== 2'd0) begin
         failures++;
         $display("FAIL idle_strobes: writes=%0d state=%0d, required 0 and 0", wr_cnt, m_state);
      end
      // Reset in the middle of POST.
      start(0, 5);
      trig_hold = 1'b1;
      sen = 1'b1;
      for (int i = 0; i < 10 && m_state != 2'd3; i++) step();
      checks++;
      if (m_state !== 2'd3 || m_wr_en !== 1'b1) begin
         failures++;
         $display("FAIL reach_post: state=%0d wr_en=%0b, required 3 and 1", m_state, m_wr_en);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({m_prev, m_data, m_wr_en, m_wr_addr, m_wr_data, m_trig_addr, m_state, m_done} !== '0) begin
         failures++;
         $display("FAIL midpost_reset: data=%0h wr_en=%0b addr=%0d trig_addr=%0d state=%0d, required all 0",
                  m_data, m_wr_en, m_wr_addr, m_trig_addr, m_state);
      end
      trig_hold = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      checks++;
      if (m_wr_en !== 1'b0 || m_state !== 2'd0 || m_data !== '0) begin
         failures++;
         $display("FAIL after_reset_idle: wr_en=%0b state=%0d data=%0h, required 0 0 0", m_wr_en, m_state, m_data);
      end
      sen = 1'b0;
   endtask

   task automatic test_basic();
      logic          post_seen;
      logic [DW-1:0] post_data;
      post_seen = 1'b0;
      post_data = '0;
      start(4, 3);
      trig_en = 1'b1;
      trig_val = 64'd10;
      sen = 1'b1;
      step();
      checks++;
      if (m_wr_en !== 1'b1 || m_wr_addr !== 10'd0 || m_data !== 64'd0 || m_state !== 2'd1) begin
         failures++;
         $display("FAIL basic_first_write: wr_en=%0b addr=%0d data=%0d state=%0d, required 1 0 0 1",
                  m_wr_en, m_wr_addr, m_data, m_state);
      end
      step();
      checks++;
      if (m_prev !== 64'd0 || m_data !== 64'd1 || m_wr_data !== 64'd1 || m_wr_addr !== 10'd1) begin
         failures++;
         $display("FAIL basic_pair: prev=%0d data=%0d wr_data=%0d addr=%0d, required 0 1 1 1",
                  m_prev, m_data, m_wr_data, m_wr_addr);
      end
      for (int i = 0; i < 40 && !m_done; i++) begin
         step();
         if (m_state == 2'd3 && !post_seen) begin post_seen = 1'b1; post_data = m_data; end
      end
      checks++;
      if (m_done !== 1'b1 || m_state !== 2'd0) begin
         failures++;
         $display("FAIL basic_done: done=%0b state=%0d, required 1 0", m_done, m_state);
      end
      checks++;
      if (seq.size() != 4 || seq[0] != 2'd1 || seq[1] != 2'd2 || seq[2] != 2'd3 || seq[3] != 2'd0) begin
         failures++;
         $display("FAIL basic_state_seq: %0d entries, required PRE WAIT POST IDLE (1 2 3 0)", seq.size());
      end
      checks++;
      if (post_data !== 64'd11) begin
         failures++;
         $display("FAIL basic_accept_latency: out_data at first POST cycle=%0d, required 11", post_data);
      end
      checks++;
      if (m_trig_addr !== 10'd10) begin
         failures++;
         $display("FAIL basic_trig_addr: got %0d, required 10", m_trig_addr);
      end
      checks++;
      if (last_addr !== 10'd13 || wr_cnt !== 14) begin
         failures++;
         $display("FAIL basic_writes: last addr=%0d count=%0d, required 13 and 14", last_addr, wr_cnt);
      end
      step(); step();
      checks++;
      if (wr_cnt !== 14 || m_done !== 1'b1) begin
         failures++;
         $display("FAIL basic_hold_done: count=%0d done=%0b, required 14 and 1", wr_cnt, m_done);
      end
      sen = 1'b0;
      trig_en = 1'b0;
   endtask

   task automatic test_pair();
      start(0, 2);
      checks++;
      if (m_state !== 2'd2) begin
         failures++;
         $display("FAIL pair_arm_wait: state=%0d, required 2", m_state);
      end
      trig_hold = 1'b1;
      sen = 1'b1;
      for (int i = 0; i < 20 && !m_done; i++) step();
      checks++;
      if (m_done !== 1'b1 || m_trig_addr !== 10'd1) begin
         failures++;
         $display("FAIL pair_trig_addr: done=%0b trig_addr=%0d, required 1 and 1", m_done, m_trig_addr);
      end
      checks++;
      if (last_addr !== 10'd3 || wr_cnt !== 4) begin
         failures++;
         $display("FAIL pair_writes: last addr=%0d count=%0d, required 3 and 4", last_addr, wr_cnt);
      end
      sen = 1'b0;
      trig_hold = 1'b0;
   endtask

   task automatic test_zero_post();
      int idx5, idxd;
      idx5 = -10;
      idxd = -1;
      start(2, 0);
      trig_en = 1'b1;
      trig_val = 64'd5;
      sen = 1'b1;
      for (int i = 0; i < 30 && !m_done; i++) begin
         step();
         if (m_wr_en && m_data == 64'd5) idx5 = i;
         if (m_done) idxd = i;
      end
      checks++;
      if (m_done !== 1'b1 || idxd != idx5 + 1) begin
         failures++;
         $display("FAIL zpost_done_timing: done=%0b at step %0d, sample 5 at step %0d, required one step later",
                  m_done, idxd, idx5);
      end
      checks++;
      if (last_addr !== 10'd5 || wr_cnt !== 6 || m_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL zpost_writes: last addr=%0d count=%0d wr_en=%0b, required 5 6 0", last_addr, wr_cnt, m_wr_en);
      end
      checks++;
      if (m_trig_addr !== 10'd5) begin
         failures++;
         $display("FAIL zpost_trig_addr: got %0d, required 5", m_trig_addr);
      end
      sen = 1'b0;
      trig_en = 1'b0;
   endtask

   task automatic test_wrap();
      logic [AWS-1:0] addr16;
      addr16 = 4'hF;
      start(3, 2);
      trig_en = 1'b1;
      trig_val = 64'd20;
      sen = 1'b1;
      for (int i = 0; i < 60 && !s_done; i++) begin
         step();
         if (s_wr_en && s_data == 64'd16) addr16 = s_wr_addr;
      end
      checks++;
      if (addr16 !== 4'd0) begin
         failures++;
         $display("FAIL wrap_addr: sample 16 written at %0d, required 0", addr16);
      end
      checks++;
      if (s_done !== 1'b1 || s_trig_addr !== 4'd4) begin
         failures++;
         $display("FAIL wrap_trig_addr: done=%0b trig_addr=%0d, required 1 and 4", s_done, s_trig_addr);
      end
      checks++;
      if (s_last !== 4'd6 || s_wr_cnt !== 23) begin
         failures++;
         $display("FAIL wrap_final: last addr=%0d count=%0d, required 6 and 23", s_last, s_wr_cnt);
      end
      sen = 1'b0;
      trig_en = 1'b0;
   endtask

   task automatic test_collisions();
      int cnt_snap;
      // Arm ignored during WAIT, then abort from POST.
      start(2, 3);
      sen = 1'b1;
      step(); step(); step(); step();
      arm = 1'b1;
      step();
      checks++;
      if (m_state !== 2'd2 || m_wr_addr !== 10'd4) begin
         failures++;
         $display("FAIL arm_in_wait: state=%0d addr=%0d, required 2 and 4", m_state, m_wr_addr);
      end
      trig_hold = 1'b1;
      step();
      checks++;
      if (m_state !== 2'd3 || m_trig_addr !== 10'd4) begin
         failures++;
         $display("FAIL wait_to_post: state=%0d trig_addr=%0d, required 3 and 4", m_state, m_trig_addr);
      end
      trig_hold = 1'b0;
      abort = 1'b1;
      step();
      checks++;
      if (m_state !== 2'd0 || m_done !== 1'b0 || m_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL abort_in_post: state=%0d done=%0b wr_en=%0b, required 0 0 0", m_state, m_done, m_wr_en);
      end
      cnt_snap = wr_cnt;
      step(); step();
      checks++;
      if (wr_cnt !== cnt_snap) begin
         failures++;
         $display("FAIL abort_no_writes: %0d writes after abort, required 0", wr_cnt - cnt_snap);
      end
      // Arm and abort together.
      sen = 1'b0;
      pre_len = 10'd2;
      arm = 1'b1;
      abort = 1'b1;
      step();
      checks++;
      if (m_state !== 2'd0) begin
         failures++;
         $display("FAIL arm_abort_same: state=%0d, required 0", m_state);
      end
      // Re-arm from DONE restarts the pointer.
      start(0, 1);
      trig_hold = 1'b1;
      sen = 1'b1;
      for (int i = 0; i < 10 && !m_done; i++) step();
      checks++;
      if (m_done !== 1'b1 || last_addr !== 10'd2) begin
         failures++;
         $display("FAIL done_before_rearm: done=%0b last addr=%0d, required 1 and 2", m_done, last_addr);
      end
      trig_hold = 1'b0;
      sen = 1'b0;
      arm = 1'b1;
      step();
      checks++;
      if (m_done !== 1'b0 || m_state !== 2'd2) begin
         failures++;
         $display("FAIL rearm_from_done: done=%0b state=%0d, required 0 and 2", m_done, m_state);
      end
      sen = 1'b1;
      step();
      checks++;
      if (m_wr_en !== 1'b1 || m_wr_addr !== 10'd0) begin
         failures++;
         $display("FAIL rearm_ptr: wr_en=%0b addr=%0d, required 1 and 0", m_wr_en, m_wr_addr);
      end
      sen = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pair();
      test_zero_post();
      test_wrap();
      test_collisions();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
